uart_fifo_core: RTL and testbench
=================================

UART_FIFO_CORE -- requirements
Module: uart_fifo_core

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame (legal 5..8).
REQ-002 Parameter OVERSAMPLE, default 16, sample ticks per bit (even, >=8).
REQ-003 Parameter DIV_BITS, default 16, width of runtime baud divisor.
REQ-004 Parameter FIFO_EXP, default 4, RX and TX FIFO depth = 2**FIFO_EXP.
REQ-005 Parameter PARITY, default 0, 0 none / 1 even / 2 odd.
REQ-006 Parameter STOP_BITS, default 1, stop bits transmitted (1 or 2); receiver checks first stop bit only.
REQ-007 clk_50MHz  in  1  sole clock; all logic on rising edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 baud_div  in  DIV_BITS  sample tick every baud_div+1 clocks.
REQ-010 echo_en  in  1  when 1, good RX bytes are also queued for TX.
REQ-011 rx  in  1  serial input, idle high, asynchronous to clock.
REQ-012 tx  out  1  serial output, idle high.
REQ-013 rx_rd  in  1  pop RX FIFO head.
REQ-014 rx_data  out  DATA_BITS  RX FIFO head (first-word-fall-through).
REQ-015 rx_empty / rx_full  out  1 each  RX FIFO status.
REQ-016 tx_wr  in  1  push tx_data into TX FIFO.
REQ-017 tx_data  in  DATA_BITS  byte to transmit.
REQ-018 tx_empty / tx_full  out  1 each  TX FIFO status.
REQ-019 tx_busy  out  1  transmitter active.
REQ-020 parity_err / frame_err  out  1 each  one-cycle error pulses.
REQ-021 overrun_cnt  out  8  RX bytes lost to full RX FIFO, saturates at 255.

Function
REQ-022 Tick generator: counter 0..baud_div, one-cycle tick at terminal count; baud_div=0 gives tick every clock; new baud_div value takes effect at next wrap.
REQ-023 rx passes a 2-FF synchroniser before use.
REQ-024 RX FSM: IDLE, START, DATA, PARITY, STOP; falling edge in IDLE -> START; PARITY skipped when PARITY=0.
REQ-025 START: at tick OVERSAMPLE/2-1 rx low -> DATA, rx high -> IDLE (glitch rejected, no error).
REQ-026 DATA/PARITY/STOP: sample every OVERSAMPLE ticks from start mid-point, data LSB first.
REQ-027 Parity mismatch -> parity_err pulse, byte discarded; stop bit low -> frame_err pulse, byte discarded; both may pulse same cycle.
REQ-028 Good byte written to RX FIFO in cycle of stop sample; RX FIFO full -> byte dropped, overrun_cnt+1 (saturating).
REQ-029 echo_en=1: good byte also pushed to TX FIFO same cycle; dropped silently if TX FIFO full or tx_wr asserted that cycle (tx_wr has priority).
REQ-030 FIFOs: write ignored when full unless read same cycle; read ignored when empty; simultaneous read+write on full performs both, occupancy unchanged; pointers wrap modulo depth.
REQ-031 TX FSM: IDLE, START, DATA, PARITY, STOP; IDLE with TX FIFO non-empty pops head and enters START next cycle; each bit OVERSAMPLE ticks; STOP lasts STOP_BITS*OVERSAMPLE ticks then IDLE.
REQ-032 tx_busy high from pop cycle through last stop tick; back-to-back bytes with no idle gap when FIFO non-empty.
REQ-033 Parity bit: even -> XOR of data; odd -> inverted XOR.

Reset
REQ-034 While reset=1: tx=1, tx_busy=0, rx_empty=tx_empty=1, rx_full=tx_full=0, rx_data=0, parity_err=frame_err=0, overrun_cnt=0, both FSMs IDLE, FIFOs and tick counter cleared.
REQ-035 Reset mid-frame aborts it immediately; tx returns high asynchronously; partial frames lost.

Verification
REQ-036 baud_div=26, 8N1, drive 0x55 on rx -> rx_empty falls, rx_data=0x55, no error pulses.
REQ-037 PARITY=1, drive 0xA7 with wrong parity bit -> one parity_err pulse, rx_empty stays 1.
REQ-038 Drive 0x3C with stop bit low -> one frame_err pulse, byte discarded.
REQ-039 Drive 17 bytes (depth 16) without rx_rd -> rx_full=1, overrun_cnt=1; drive 300 more -> overrun_cnt=255.
REQ-040 tx_wr 0x41,0x42 consecutive cycles -> tx frames back-to-back LSB first, tx_busy continuous, tx_empty=1 after pop of 0x42.
REQ-041 echo_en=1, drive 0x5A on rx -> 0x5A in RX FIFO and retransmitted on tx; assert reset mid-echo -> tx=1, all status at reset values.

Source files
------------

// File: rtl/uart_fifo_core.sv
// UART with oversampled receiver, transmitter and RX/TX FIFOs.
// Optional echo path re-queues good RX bytes for transmission.
module uart_fifo_core_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wptr, rptr;
    logic         do_wr, do_rd;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || rd);
    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
        end
    end
endmodule

module uart_fifo_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_BITS   = 16,
    parameter int FIFO_EXP   = 4,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk_50MHz,
    input  logic                 reset,
    input  logic [DIV_BITS-1:0]  baud_div,
    input  logic                 echo_en,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 rx_rd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_empty,
    output logic                 rx_full,
    input  logic                 tx_wr,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_empty,
    output logic                 tx_full,
    output logic                 tx_busy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic [7:0]           overrun_cnt
);
    localparam int CW = $clog2(OVERSAMPLE * STOP_BITS) + 1;
    localparam logic [CW-1:0] HALF  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] STOPN = CW'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [2:0]    LAST  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP
    } state_t;

    // Divisor is latched at wrap so a live change never shortens a tick.
    logic [DIV_BITS-1:0] div_q, tick_cnt;
    logic                tick;

    assign tick = (tick_cnt == div_q);

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            div_q    <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
            div_q    <= baud_div;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    state_t               rx_state, rx_next;
    logic                 rx_m, rx_s, rx_d;
    logic [CW-1:0]        rx_cnt;
    logic [2:0]           rx_bcnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par;
    logic                 rx_fall, rx_hit, rx_stop, par_ok, rx_good;

    assign rx_fall = rx_d && !rx_s;
    assign rx_hit  = tick && (rx_cnt == ((rx_state == S_START) ? HALF : FULL));
    assign rx_stop = (rx_state == S_STOP) && rx_hit;
    assign par_ok  = (PARITY == 0) ||
                     (rx_par == ((^rx_shift) ^ (PARITY == 2)));
    assign parity_err = rx_stop && !par_ok;
    assign frame_err  = rx_stop && !rx_s;
    assign rx_good    = rx_stop && rx_s && par_ok;

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            S_IDLE:  if (rx_fall) rx_next = S_START;
            S_START: if (rx_hit) rx_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (rx_hit && rx_bcnt == LAST)
                         rx_next = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (rx_hit) rx_next = S_STOP;
            S_STOP:  if (rx_hit) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            rx_m     <= 1'b1;
            rx_s     <= 1'b1;
            rx_d     <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bcnt  <= '0;
            rx_shift <= '0;
            rx_par   <= 1'b0;
        end else begin
            rx_m     <= rx;
            rx_s     <= rx_m;
            rx_d     <= rx_s;
            rx_state <= rx_next;
            if (rx_state == S_IDLE) rx_cnt <= '0;
            else if (tick) rx_cnt <= rx_hit ? '0 : rx_cnt + 1'b1;
            if (rx_state == S_START) rx_bcnt <= '0;
            if (rx_state == S_DATA && rx_hit) begin
                rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                rx_bcnt  <= rx_bcnt + 3'd1;
            end
            if (rx_state == S_PAR && rx_hit) rx_par <= rx_s;
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) overrun_cnt <= '0;
        else if (rx_good && rx_full && !rx_rd && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
    end

    logic                 txf_wr, tx_pop;
    logic [DATA_BITS-1:0] txf_wdata, tx_head;

    assign txf_wr    = tx_wr || (echo_en && rx_good);
    assign txf_wdata = tx_wr ? tx_data : rx_shift;

    uart_fifo_core_fifo #(.W(DATA_BITS), .AW(FIFO_EXP)) u_rx_fifo (
        .clk   (clk_50MHz),
        .reset (reset),
        .wr    (rx_good),
        .wdata (rx_shift),
        .rd    (rx_rd),
        .rdata (rx_data),
        .empty (rx_empty),
        .full  (rx_full)
    );

    uart_fifo_core_fifo #(.W(DATA_BITS), .AW(FIFO_EXP)) u_tx_fifo (
        .clk   (clk_50MHz),
        .reset (reset),
        .wr    (txf_wr),
        .wdata (txf_wdata),
        .rd    (tx_pop),
        .rdata (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    state_t               tx_state, tx_next;
    logic [CW-1:0]        tx_cnt;
    logic [2:0]           tx_bcnt;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par, tx_hit;

    assign tx_hit  = tick && (tx_cnt == ((tx_state == S_STOP) ? STOPN : FULL));
    assign tx_busy = (tx_state != S_IDLE) || tx_pop;

    // Popping at the last stop tick chains frames with no idle gap.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        unique case (tx_state)
            S_IDLE: if (!tx_empty) begin
                tx_pop  = 1'b1;
                tx_next = S_START;
            end
            S_START: if (tx_hit) tx_next = S_DATA;
            S_DATA:  if (tx_hit && tx_bcnt == LAST)
                         tx_next = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (tx_hit) tx_next = S_STOP;
            S_STOP:  if (tx_hit) begin
                if (!tx_empty) begin
                    tx_pop  = 1'b1;
                    tx_next = S_START;
                end else begin
                    tx_next = S_IDLE;
                end
            end
            default: tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        unique case (tx_state)
            S_START: tx = 1'b0;
            S_DATA:  tx = tx_shift[0];
            S_PAR:   tx = tx_par;
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bcnt  <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_par   <= (^tx_head) ^ (PARITY == 2);
                tx_bcnt  <= '0;
                tx_cnt   <= '0;
            end else if (tx_state == S_IDLE) begin
                tx_cnt <= '0;
            end else if (tick) begin
                tx_cnt <= tx_hit ? '0 : tx_cnt + 1'b1;
            end
            if (tx_state == S_DATA && tx_hit) begin
                tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                tx_bcnt  <= tx_bcnt + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed testbench for uart_fifo_core.
// Drives serial frames, checks FIFOs, errors, TX and echo.
module tb_uart_fifo_core;
    logic        clk_50MHz = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] baud_div = 16'd26;
    logic        echo_en = 1'b0;
    logic        rx = 1'b1;
    logic        rx_p = 1'b1;
    logic        rx_rd = 1'b0;
    logic        tx_wr = 1'b0;
    logic [7:0]  tx_data = 8'h00;

    logic       tx, rx_empty, rx_full, tx_empty, tx_full, tx_busy;
    logic       parity_err, frame_err;
    logic [7:0] rx_data, overrun_cnt;

    logic       tx_p, rx_empty_p, rx_full_p, tx_empty_p, tx_full_p, tx_busy_p;
    logic       parity_err_p, frame_err_p;
    logic [7:0] rx_data_p, overrun_cnt_p;

    int vectors = 0;
    int miscompares = 0;
    int pe_cnt = 0, fe_cnt = 0, pe_cnt_p = 0, fe_cnt_p = 0;

    always #10 clk_50MHz = ~clk_50MHz;

    uart_fifo_core dut (
        .clk_50MHz   (clk_50MHz),
        .reset       (reset),
        .baud_div    (baud_div),
        .echo_en     (echo_en),
        .rx          (rx),
        .tx          (tx),
        .rx_rd       (rx_rd),
        .rx_data     (rx_data),
        .rx_empty    (rx_empty),
        .rx_full     (rx_full),
        .tx_wr       (tx_wr),
        .tx_data     (tx_data),
        .tx_empty    (tx_empty),
        .tx_full     (tx_full),
        .tx_busy     (tx_busy),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_cnt (overrun_cnt)
    );

    uart_fifo_core #(.PARITY(1)) dut_p (
        .clk_50MHz   (clk_50MHz),
        .reset       (reset),
        .baud_div    (baud_div),
        .echo_en     (1'b0),
        .rx          (rx_p),
        .tx          (tx_p),
        .rx_rd       (1'b0),
        .rx_data     (rx_data_p),
        .rx_empty    (rx_empty_p),
        .rx_full     (rx_full_p),
        .tx_wr       (1'b0),
        .tx_data     (8'h00),
        .tx_empty    (tx_empty_p),
        .tx_full     (tx_full_p),
        .tx_busy     (tx_busy_p),
        .parity_err  (parity_err_p),
        .frame_err   (frame_err_p),
        .overrun_cnt (overrun_cnt_p)
    );

    always @(negedge clk_50MHz) begin
        if (parity_err)   pe_cnt++;
        if (frame_err)    fe_cnt++;
        if (parity_err_p) pe_cnt_p++;
        if (frame_err_p)  fe_cnt_p++;
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_50MHz);
        reset = 1'b0;
        repeat (2) @(negedge clk_50MHz);
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) rx_p = v;
        else rx = v;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d,
                              input bit has_par, input logic pbit,
                              input logic sbit, input int bc, input int gap);
        set_rx(sel, 1'b0);
        repeat (bc) @(negedge clk_50MHz);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, d[i]);
            repeat (bc) @(negedge clk_50MHz);
        end
        if (has_par) begin
            set_rx(sel, pbit);
            repeat (bc) @(negedge clk_50MHz);
        end
        set_rx(sel, sbit);
        repeat (bc) @(negedge clk_50MHz);
        set_rx(sel, 1'b1);
        repeat (gap) @(negedge clk_50MHz);
    endtask

    task automatic test_reset();
        logic [7:0] st;
        reset = 1'b1;
        baud_div = 16'd26;
        repeat (3) @(negedge clk_50MHz);
        st = {tx, tx_busy, rx_empty, tx_empty, rx_full, tx_full,
              parity_err, frame_err};
        vectors++;
        if (st !== 8'b1011_0000) begin
            miscompares++;
            $display("FAIL reset_status: got %b want 10110000", st);
        end
        vectors++;
        if (rx_data !== 8'h00 || overrun_cnt !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_data: rx_data %h ovr %h want 00 00",
                     rx_data, overrun_cnt);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk_50MHz);
        vectors++;
        if ({tx, tx_busy, rx_empty} !== 3'b101) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b want 101",
                     {tx, tx_busy, rx_empty});
        end
    endtask

    task automatic test_rx_basic();
        int pe0, fe0;
        baud_div = 16'd26;
        do_reset();
        pe0 = pe_cnt;
        fe0 = fe_cnt;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 432, 432);
        vectors++;
        if (rx_empty !== 1'b0) begin
            miscompares++;
            $display("FAIL rx55_empty: got %b want 0", rx_empty);
        end
        vectors++;
        if (rx_data !== 8'h55) begin
            miscompares++;
            $display("FAIL rx55_data: got %h want 55", rx_data);
        end
        vectors++;
        if (pe_cnt - pe0 != 0 || fe_cnt - fe0 != 0) begin
            miscompares++;
            $display("FAIL rx55_errors: pe %0d fe %0d want 0 0",
                     pe_cnt - pe0, fe_cnt - fe0);
        end
        rx_rd = 1'b1;
        @(negedge clk_50MHz);
        rx_rd = 1'b0;
        vectors++;
        if (rx_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL rx55_pop: got %b want 1", rx_empty);
        end
    endtask

    task automatic test_parity();
        int pe0, fe0;
        baud_div = 16'd3;
        do_reset();
        pe0 = pe_cnt_p;
        fe0 = fe_cnt_p;
        send_frame(1'b1, 8'hA7, 1'b1, 1'b0, 1'b1, 64, 64);
        vectors++;
        if (pe_cnt_p - pe0 != 1) begin
            miscompares++;
            $display("FAIL parity_pulse: got %0d want 1", pe_cnt_p - pe0);
        end
        vectors++;
        if (rx_empty_p !== 1'b1 || fe_cnt_p - fe0 != 0) begin
            miscompares++;
            $display("FAIL parity_discard: empty %b fe %0d want 1 0",
                     rx_empty_p, fe_cnt_p - fe0);
        end
        send_frame(1'b1, 8'hA7, 1'b1, 1'b1, 1'b1, 64, 64);
        vectors++;
        if (rx_empty_p !== 1'b0 || rx_data_p !== 8'hA7) begin
            miscompares++;
            $display("FAIL parity_good: empty %b data %h want 0 a7",
                     rx_empty_p, rx_data_p);
        end
        vectors++;
        if (pe_cnt_p - pe0 != 1) begin
            miscompares++;
            $display("FAIL parity_good_err: got %0d want 1", pe_cnt_p - pe0);
        end
    endtask

    task automatic test_frame();
        int pe0, fe0;
        baud_div = 16'd3;
        do_reset();
        pe0 = pe_cnt;
        fe0 = fe_cnt;
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 64, 64);
        vectors++;
        if (fe_cnt - fe0 != 1) begin
            miscompares++;
            $display("FAIL frame_pulse: got %0d want 1", fe_cnt - fe0);
        end
        vectors++;
        if (rx_empty !== 1'b1 || pe_cnt - pe0 != 0) begin
            miscompares++;
            $display("FAIL frame_discard: empty %b pe %0d want 1 0",
                     rx_empty, pe_cnt - pe0);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] got;
        logic [19:0] exp;
        logic        empt_mid, empt_late;
        int          busy_low;
        int          k;
        exp = {1'b1, 8'h42, 1'b0, 1'b1, 8'h41, 1'b0};
        got = '0;
        busy_low = 0;
        empt_mid = 1'bx;
        empt_late = 1'bx;
        baud_div = 16'd3;
        do_reset();
        tx_data = 8'h41;
        tx_wr = 1'b1;
        @(negedge clk_50MHz);
        tx_data = 8'h42;
        vectors++;
        if (tx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL tx_busy_pop: got %b want 1", tx_busy);
        end
        @(negedge clk_50MHz);
        tx_wr = 1'b0;
        for (k = 0; k < 200 && tx !== 1'b0; k++) @(negedge clk_50MHz);
        vectors++;
        if (tx !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_start_timeout: tx %b want 0", tx);
        end
        for (int i = 1; i <= 20 * 64; i++) begin
            @(negedge clk_50MHz);
            if (i % 64 == 32) got[i / 64] = tx;
            if (i < 20 * 64 - 8 && !tx_busy) busy_low++;
            if (i == 5 * 64) empt_mid = tx_empty;
            if (i == 10 * 64 + 32) empt_late = tx_empty;
        end
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL tx_frames: got %b want %b", got, exp);
        end
        vectors++;
        if (busy_low != 0) begin
            miscompares++;
            $display("FAIL tx_busy_gap: low cycles %0d want 0", busy_low);
        end
        vectors++;
        if ({empt_mid, empt_late} !== 2'b01) begin
            miscompares++;
            $display("FAIL tx_empty_seq: got %b want 01",
                     {empt_mid, empt_late});
        end
        repeat (8) @(negedge clk_50MHz);
        vectors++;
        if ({tx, tx_busy, tx_empty} !== 3'b101) begin
            miscompares++;
            $display("FAIL tx_done: got %b want 101",
                     {tx, tx_busy, tx_empty});
        end
    endtask

    task automatic test_echo_reset();
        logic [7:0] got;
        bit         tmo;
        got = '0;
        tmo = 1'b0;
        baud_div = 16'd3;
        do_reset();
        echo_en = 1'b1;
        fork
            send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 64, 0);
            begin
                for (int k = 0; k < 2000 && tx !== 1'b0; k++)
                    @(negedge clk_50MHz);
                if (tx !== 1'b0) tmo = 1'b1;
                repeat (32) @(negedge clk_50MHz);
                for (int b = 0; b < 8; b++) begin
                    repeat (64) @(negedge clk_50MHz);
                    got[b] = tx;
                end
            end
        join
        vectors++;
        if (tmo || got !== 8'h5A) begin
            miscompares++;
            $display("FAIL echo_tx: got %h timeout %b want 5a", got, tmo);
        end
        vectors++;
        if (rx_empty !== 1'b0 || rx_data !== 8'h5A) begin
            miscompares++;
            $display("FAIL echo_rx: empty %b data %h want 0 5a",
                     rx_empty, rx_data);
        end
        vectors++;
        if ({tx, tx_busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL echo_mid: got %b want 01", {tx, tx_busy});
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({tx, tx_busy, rx_empty, tx_empty, rx_full, tx_full} !== 6'b101100) begin
            miscompares++;
            $display("FAIL echo_reset_status: got %b want 101100",
                     {tx, tx_busy, rx_empty, tx_empty, rx_full, tx_full});
        end
        vectors++;
        if (rx_data !== 8'h00 || overrun_cnt !== 8'h00) begin
            miscompares++;
            $display("FAIL echo_reset_data: data %h ovr %h want 00 00",
                     rx_data, overrun_cnt);
        end
        echo_en = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        reset = 1'b0;
        repeat (2) @(negedge clk_50MHz);
    endtask

    task automatic test_overrun();
        baud_div = 16'd0;
        do_reset();
        for (int i = 0; i < 16; i++)
            send_frame(1'b0, 8'(160 + i), 1'b0, 1'b0, 1'b1, 16, 0);
        repeat (16) @(negedge clk_50MHz);
        vectors++;
        if (rx_full !== 1'b1 || overrun_cnt !== 8'd0 || rx_data !== 8'hA0) begin
            miscompares++;
            $display("FAIL fill16: full %b ovr %0d data %h want 1 0 a0",
                     rx_full, overrun_cnt, rx_data);
        end
        send_frame(1'b0, 8'hB0, 1'b0, 1'b0, 1'b1, 16, 16);
        vectors++;
        if (overrun_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL overrun_1: got %0d want 1", overrun_cnt);
        end
        for (int i = 0; i < 300; i++)
            send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1, 16, 0);
        repeat (16) @(negedge clk_50MHz);
        vectors++;
        if (overrun_cnt !== 8'd255 || rx_full !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sat: ovr %0d full %b want 255 1",
                     overrun_cnt, rx_full);
        end
        rx_rd = 1'b1;
        @(negedge clk_50MHz);
        rx_rd = 1'b0;
        vectors++;
        if (rx_data !== 8'hA1 || rx_full !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_pop: data %h full %b want a1 0",
                     rx_data, rx_full);
        end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_parity();
        test_frame();
        test_back_to_back();
        test_echo_reset();
        test_overrun();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
